abm_mux_ctrl: RTL

//  Safe switch controller for the 2:1 AXI4-MM slave-select mux. Drives the mux's

---
 rtl/abm_mux_ctrl_if.sv | 25 ++
 rtl/abm_mux_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/abm_mux_ctrl_if.sv
// Mux-output AW/AR valid/ready pairs plus W/B/R snoop signals for abm_mux_ctrl.
// slave: controller view; master: the surrounding mux/downstream view.
interface abm_mux_ctrl_if;
  logic S_AXI_AWVALID, S_AXI_AWREADY, M_AXI_AWVALID, M_AXI_AWREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
  logic M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST;

  modport slave (
    input  S_AXI_AWVALID, M_AXI_AWREADY, S_AXI_ARVALID, M_AXI_ARREADY,
    input  M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST,
    input  M_AXI_BVALID, M_AXI_BREADY,
    input  M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST,
    output S_AXI_AWREADY, M_AXI_AWVALID, S_AXI_ARREADY, M_AXI_ARVALID
  );

  modport master (
    output S_AXI_AWVALID, M_AXI_AWREADY, S_AXI_ARVALID, M_AXI_ARREADY,
    output M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST,
    output M_AXI_BVALID, M_AXI_BREADY,
    output M_AXI_RVALID, M_AXI_RREADY, M_AXI_RLAST,
    input  S_AXI_AWREADY, M_AXI_AWVALID, S_AXI_ARREADY, M_AXI_ARVALID
  );
endinterface

// File: rtl/abm_mux_ctrl.sv
// Safe select switch for a 2:1 AXI4-MM slave mux: drains outstanding traffic before flipping.
// Optional drain-timeout flag enabled by `define ABM_MUX_CTRL_TIMEOUT_EN.
module abm_mux_ctrl #(
  parameter int unsigned MAX_OUT        = 16,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           select_req,
  output logic           select_s1,
  output logic           sel_ready,
  output logic           drain_timeout,
  abm_mux_ctrl_if.slave  axi
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUT);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("abm_mux_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {RUN, DRAIN, SETTLE} state_t;

  state_t        state, state_nxt;
  logic          flip;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [SW-1:0] settle_cnt;
  logic          w_open, aw_hold, ar_hold;
  logic          aw_gate, ar_gate;
  logic          aw_acc, ar_acc, b_acc, r_acc, w_beat;
  logic          drained;

  // A held (presented, not yet accepted) address keeps its gate open regardless of state.
  assign aw_gate = ((state == RUN) && (wr_cnt < MAX_CNT)) || aw_hold;
  assign ar_gate = ((state == RUN) && (rd_cnt < MAX_CNT)) || ar_hold;

  assign axi.M_AXI_AWVALID = axi.S_AXI_AWVALID & aw_gate;
  assign axi.S_AXI_AWREADY = axi.M_AXI_AWREADY & aw_gate;
  assign axi.M_AXI_ARVALID = axi.S_AXI_ARVALID & ar_gate;
  assign axi.S_AXI_ARREADY = axi.M_AXI_ARREADY & ar_gate;

  assign aw_acc = axi.M_AXI_AWVALID & axi.M_AXI_AWREADY;
  assign ar_acc = axi.M_AXI_ARVALID & axi.M_AXI_ARREADY;
  assign b_acc  = axi.M_AXI_BVALID & axi.M_AXI_BREADY;
  assign r_acc  = axi.M_AXI_RVALID & axi.M_AXI_RREADY & axi.M_AXI_RLAST;
  assign w_beat = axi.M_AXI_WVALID & axi.M_AXI_WREADY;

  assign drained = (wr_cnt == '0) && (rd_cnt == '0) && !w_open && !aw_hold && !ar_hold;

  assign sel_ready = (state == RUN) && (select_s1 == select_req);

  always_comb begin
    state_nxt = state;
    flip      = 1'b0;
    case (state)
      RUN:    if (select_req != select_s1) state_nxt = DRAIN;
      DRAIN: begin
        if (select_req == select_s1) begin
          state_nxt = RUN;
        end else if (drained) begin
          state_nxt = SETTLE;
          flip      = 1'b1;
        end
      end
      SETTLE: if (settle_cnt == SETTLE_END) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RUN;
      select_s1  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (flip) select_s1 <= select_req;
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                 settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      w_open  <= 1'b0;
      aw_hold <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      if (aw_acc && !b_acc)                       wr_cnt <= wr_cnt + 1'b1;
      else if (!aw_acc && b_acc && wr_cnt != '0)  wr_cnt <= wr_cnt - 1'b1;
      if (ar_acc && !r_acc)                       rd_cnt <= rd_cnt + 1'b1;
      else if (!ar_acc && r_acc && rd_cnt != '0)  rd_cnt <= rd_cnt - 1'b1;
      if (w_beat) w_open <= !axi.M_AXI_WLAST;
      aw_hold <= axi.M_AXI_AWVALID & ~axi.M_AXI_AWREADY;
      ar_hold <= axi.M_AXI_ARVALID & ~axi.M_AXI_ARREADY;
    end
  end

`ifdef ABM_MUX_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == DRAIN) begin
      if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) to_flag <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign drain_timeout = to_flag;
`else
  assign drain_timeout = 1'b0;
`endif

endmodule
